// File: rtl/inst_queue_pkg.sv
// Shared CPU package (cpu_pkg) holding the instruction-queue types and constants.
//   iq_entry_t : one queued instruction {pc, inst, exc}
//   EXC_*      : 2-bit fetch exception codes {addr-error, fetch-fault}
//   IQ_DEPTH   : default number of queue entries
package cpu_pkg;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ADEL  = 2'b10;
  localparam logic [1:0] EXC_FETCH = 2'b01;

  localparam int unsigned IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
  } iq_entry_t;

  // Smaller of two 2-bit counts.
  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle of the instruction queue.
//   in_*        : fetch side, one instruction per cycle with in_ready back-pressure
//   out_*0/1    : two oldest entries presented to the dual decoders
//   issue_cnt   : entries decode consumed this cycle (0..2)
//   count       : current occupancy
// Modports: slave = the queue, master = fetch/decode environment.
interface inst_queue_if #(
  parameter int unsigned PTR_W = 3
);

  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic [1:0]       in_exc;
  logic             in_ready;

  logic             out_valid0;
  logic [31:0]      out_pc0;
  logic [31:0]      out_inst0;
  logic [1:0]       out_exc0;
  logic             out_valid1;
  logic [31:0]      out_pc1;
  logic [31:0]      out_inst1;
  logic [1:0]       out_exc1;

  logic [1:0]       issue_cnt;
  logic [PTR_W:0]   count;

  modport slave (
    input  in_valid, in_pc, in_inst, in_exc, issue_cnt,
    output in_ready,
    output out_valid0, out_pc0, out_inst0, out_exc0,
    output out_valid1, out_pc1, out_inst1, out_exc1,
    output count
  );

  modport master (
    output in_valid, in_pc, in_inst, in_exc, issue_cnt,
    input  in_ready,
    input  out_valid0, out_pc0, out_inst0, out_exc0,
    input  out_valid1, out_pc1, out_inst1, out_exc1,
    input  count
  );

endinterface

// File: rtl/inst_queue_ram.sv
// Entry storage of the instruction queue: DEPTH x iq_entry_t register array.
//   clk_i              : rising-edge clock
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr0_i/rdata0_o  : asynchronous read port (oldest slot)
//   raddr1_i/rdata1_o  : asynchronous read port (second-oldest slot)
module inst_queue_ram
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  iq_entry_t        wdata_i,
  input  logic [PTR_W-1:0] raddr0_i,
  output iq_entry_t        rdata0_o,
  input  logic [PTR_W-1:0] raddr1_i,
  output iq_entry_t        rdata1_o
);

  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low reset (behaves like flush)
//   flush : discard all entries on redirect; highest priority
//   bus   : inst_queue_if.slave carrying the fetch push, the two decode slots,
//           issue_cnt and the occupancy count
// Build option: define INST_QUEUE_BYPASS_EN to forward an incoming instruction
// straight to slot 0 when the queue is empty (0-cycle fetch-to-decode).
module inst_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  inst_queue_if.slave  bus
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_nxt;

  iq_entry_t rd0, rd1, wr_entry, out0, out1;
  logic      in_ready;
  logic      stored0, stored1;
  logic      valid0, valid1;
  logic      bypass;
  logic      push, ram_we;
  logic [1:0] issuable, eff, pop_cnt;

  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign wr_entry   = '{pc: bus.in_pc, inst: bus.in_inst, exc: bus.in_exc};

  inst_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk_i    (clk),
    .we_i     (ram_we),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (wr_entry),
    .raddr0_i (rd_ptr_q),
    .rdata0_o (rd0),
    .raddr1_i (rd_ptr_nxt),
    .rdata1_o (rd1)
  );

  // Occupancy never exceeds DEPTH (a power of two), so the MSB alone means full.
  assign in_ready = ~count_q[PTR_W];
  assign stored0  = (count_q != '0);
  assign stored1  = (count_q > (PTR_W+1)'(1));

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && bus.in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // Slot presentation. Unused slots read as zero so nothing undefined leaks out
  // of the unreset storage array.
  always_comb begin
    valid0 = 1'b0;
    valid1 = 1'b0;
    out0   = '0;
    out1   = '0;
    if (bypass) begin
      valid0 = 1'b1;
      out0   = wr_entry;
    end else begin
      valid0 = stored0;
      if (stored0) out0 = rd0;
      if (stored1) out1 = rd1;
      // A faulting instruction must issue alone in slot 0.
      valid1 = stored1 && (rd0.exc == EXC_NONE) && (rd1.exc == EXC_NONE);
    end
  end

  always_comb begin
    issuable = {1'b0, valid0} + {1'b0, valid1};
    eff      = min2(bus.issue_cnt, issuable);
    // A bypassed instruction is consumed straight from the fetch bus.
    pop_cnt  = bypass ? 2'd0 : eff;
    push     = bus.in_valid && in_ready && !flush && !(bypass && (eff != 2'd0));
    ram_we   = push && reset;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (!reset || flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid0 = valid0;
  assign bus.out_pc0    = out0.pc;
  assign bus.out_inst0  = out0.inst;
  assign bus.out_exc0   = out0.exc;
  assign bus.out_valid1 = valid1;
  assign bus.out_pc1    = out1.pc;
  assign bus.out_inst1  = out1.inst;
  assign bus.out_exc1   = out1.exc;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
module tb_inst_queue;

  logic clk;
  logic reset;
  logic flush;
  int   n_pass;
  int   n_total;

  inst_queue_if #(.PTR_W(3)) bus ();

  inst_queue #(
    .DEPTH (8),
    .PTR_W (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_pc     = 32'h0;
    bus.in_inst   = 32'h0;
    bus.in_exc    = 2'b00;
    bus.issue_cnt = 2'd0;
    flush         = 1'b0;
  endtask

  task automatic push_pc(input logic [31:0] pc, input logic [1:0] exc);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = (exc == 2'b00) ? (pc ^ 32'h00a5_0000) : 32'h0;
    bus.in_exc   = exc;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    n_total++; if (bus.count !== 4'd0) $display("FAIL reset_count got %0d want 0", bus.count); else n_pass++;
    n_total++; if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0)
      $display("FAIL reset_valid got %b%b want 00", bus.out_valid0, bus.out_valid1); else n_pass++;
    n_total++; if (bus.out_pc0 !== 32'h0 || bus.out_inst0 !== 32'h0 || bus.out_exc0 !== 2'b00)
      $display("FAIL reset_slot0 got %h/%h/%b want zeros", bus.out_pc0, bus.out_inst0, bus.out_exc0);
    else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_dual_issue();
    for (int i = 0; i < 3; i++) begin
      push_pc(32'hbfc0_0000 + 32'(4 * i), 2'b00);
      step();
    end
    idle();
    #1;
    n_total++; if (bus.count !== 4'd3) $display("FAIL fill3_count got %0d want 3", bus.count); else n_pass++;
    n_total++; if (bus.out_pc0 !== 32'hbfc0_0000 || bus.out_pc1 !== 32'hbfc0_0004)
      $display("FAIL fill3_pcs got %h/%h want bfc00000/bfc00004", bus.out_pc0, bus.out_pc1); else n_pass++;
    n_total++; if (bus.out_valid0 !== 1'b1 || bus.out_valid1 !== 1'b1)
      $display("FAIL fill3_valid got %b%b want 11", bus.out_valid0, bus.out_valid1); else n_pass++;
    n_total++; if (bus.out_inst0 !== (32'hbfc0_0000 ^ 32'h00a5_0000))
      $display("FAIL fill3_inst0 got %h want %h", bus.out_inst0, 32'hbfc0_0000 ^ 32'h00a5_0000);
    else n_pass++;
    push_pc(32'hbfc0_000c, 2'b00);
    bus.issue_cnt = 2'd2;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd2) $display("FAIL dual_count got %0d want 2", bus.count); else n_pass++;
    n_total++; if (bus.out_pc0 !== 32'hbfc0_0008 || bus.out_pc1 !== 32'hbfc0_000c)
      $display("FAIL dual_pcs got %h/%h want bfc00008/bfc0000c", bus.out_pc0, bus.out_pc1); else n_pass++;
    bus.issue_cnt = 2'd2;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd0) $display("FAIL dual_drain got %0d want 0", bus.count); else n_pass++;
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 8; i++) begin
      push_pc(32'h0000_1000 + 32'(4 * i), 2'b00);
      step();
    end
    idle();
    #1;
    n_total++; if (bus.count !== 4'd8 || bus.in_ready !== 1'b0)
      $display("FAIL full_state got cnt=%0d rdy=%b want cnt=8 rdy=0", bus.count, bus.in_ready);
    else n_pass++;
    push_pc(32'h0000_dead, 2'b00);
    step();
    #1;
    n_total++; if (bus.count !== 4'd8) $display("FAIL full_nostore got %0d want 8", bus.count); else n_pass++;
    // Pop while full: the same-cycle pop must not admit the push.
    bus.issue_cnt = 2'd2;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd6 || bus.in_ready !== 1'b1)
      $display("FAIL full_pop got cnt=%0d rdy=%b want cnt=6 rdy=1", bus.count, bus.in_ready);
    else n_pass++;
    n_total++; if (bus.out_pc0 !== 32'h0000_1008) $display("FAIL full_pop_pc got %h want 00001008", bus.out_pc0);
    else n_pass++;
    for (int k = 0; k < 20; k++) begin
      push_pc(32'h0000_1000 + 32'(4 * (8 + k)), 2'b00);
      bus.issue_cnt = 2'd1;
      #1;
      n_total++; if (bus.out_pc0 !== 32'h0000_1000 + 32'(4 * (2 + k)))
        $display("FAIL wrap_order[%0d] got %h want %h", k, bus.out_pc0, 32'h0000_1000 + 32'(4 * (2 + k)));
      else n_pass++;
      step();
    end
    idle();
    #1;
    n_total++; if (bus.count !== 4'd6) $display("FAIL wrap_count got %0d want 6", bus.count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bus.issue_cnt = 2'd2;
      step();
    end
    idle();
    #1;
    n_total++; if (bus.count !== 4'd0) $display("FAIL wrap_drain got %0d want 0", bus.count); else n_pass++;
  endtask

  task automatic test_exc();
    push_pc(32'h0000_2000, 2'b00);
    step();
    push_pc(32'h0000_2004, 2'b10);
    step();
    push_pc(32'h0000_2008, 2'b00);
    step();
    idle();
    #1;
    n_total++; if (bus.out_valid0 !== 1'b1 || bus.out_valid1 !== 1'b0)
      $display("FAIL exc_second got %b%b want 10", bus.out_valid0, bus.out_valid1); else n_pass++;
    bus.issue_cnt = 2'd2;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd2) $display("FAIL exc_clamp got %0d want 2", bus.count); else n_pass++;
    n_total++; if (bus.out_pc0 !== 32'h0000_2004 || bus.out_exc0 !== 2'b10 || bus.out_inst0 !== 32'h0)
      $display("FAIL exc_slot0 got %h/%b/%h want 00002004/10/00000000",
               bus.out_pc0, bus.out_exc0, bus.out_inst0);
    else n_pass++;
    n_total++; if (bus.out_valid1 !== 1'b0) $display("FAIL exc_alone got %b want 0", bus.out_valid1); else n_pass++;
    bus.issue_cnt = 2'd2;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd1 || bus.out_pc0 !== 32'h0000_2008)
      $display("FAIL exc_after got cnt=%0d pc=%h want 1/00002008", bus.count, bus.out_pc0); else n_pass++;
    bus.issue_cnt = 2'd1;
    step();
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      push_pc(32'h0000_3000 + 32'(4 * i), 2'b00);
      step();
    end
    idle();
    #1;
    n_total++; if (bus.count !== 4'd5) $display("FAIL flush_pre got %0d want 5", bus.count); else n_pass++;
    push_pc(32'h0000_3333, 2'b00);
    bus.issue_cnt = 2'd2;
    flush = 1'b1;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd0 || bus.out_valid0 !== 1'b0)
      $display("FAIL flush_clear got cnt=%0d v0=%b want 0/0", bus.count, bus.out_valid0); else n_pass++;
    push_pc(32'h0000_4000, 2'b00);
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd1 || bus.out_pc0 !== 32'h0000_4000 || bus.out_valid1 !== 1'b0)
      $display("FAIL flush_after got cnt=%0d pc=%h v1=%b want 1/00004000/0",
               bus.count, bus.out_pc0, bus.out_valid1);
    else n_pass++;
    bus.issue_cnt = 2'd1;
    step();
    idle();
  endtask

  task automatic test_empty();
    bus.issue_cnt = 2'd2;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd0 || bus.out_valid0 !== 1'b0)
      $display("FAIL empty_issue got cnt=%0d v0=%b want 0/0", bus.count, bus.out_valid0); else n_pass++;
    push_pc(32'h0000_5000, 2'b00);
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd1 || bus.out_pc0 !== 32'h0000_5000)
      $display("FAIL empty_ptrs got cnt=%0d pc=%h want 1/00005000", bus.count, bus.out_pc0); else n_pass++;
    bus.issue_cnt = 2'd1;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    push_pc(32'h0000_6000, 2'b00);
    step();
    push_pc(32'h0000_6004, 2'b00);
    step();
    push_pc(32'h0000_6008, 2'b00);
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle();
    #1;
    n_total++; if (bus.count !== 4'd0 || bus.out_valid0 !== 1'b0)
      $display("FAIL midreset got cnt=%0d v0=%b want 0/0", bus.count, bus.out_valid0); else n_pass++;
  endtask

  task automatic test_bypass();
    push_pc(32'hbfc0_0010, 2'b00);
    bus.issue_cnt = 2'd1;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    n_total++; if (bus.out_valid0 !== 1'b1 || bus.out_pc0 !== 32'hbfc0_0010 || bus.out_valid1 !== 1'b0)
      $display("FAIL bypass_slot0 got v0=%b pc=%h v1=%b want 1/bfc00010/0",
               bus.out_valid0, bus.out_pc0, bus.out_valid1);
    else n_pass++;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd0 || bus.out_valid0 !== 1'b0)
      $display("FAIL bypass_count got cnt=%0d v0=%b want 0/0", bus.count, bus.out_valid0); else n_pass++;
`else
    n_total++; if (bus.out_valid0 !== 1'b0)
      $display("FAIL nobypass_slot0 got v0=%b want 0", bus.out_valid0); else n_pass++;
    step();
    idle();
    #1;
    n_total++; if (bus.count !== 4'd1 || bus.out_pc0 !== 32'hbfc0_0010)
      $display("FAIL nobypass_latency got cnt=%0d pc=%h want 1/bfc00010", bus.count, bus.out_pc0);
    else n_pass++;
`endif
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    idle();
    test_reset();
    test_dual_issue();
    test_full_wrap();
    test_exc();
    test_flush();
    test_empty();
    test_reset_mid();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Dual-issue instruction queue between the fetch stage and decode (ID).
- Accepts one fetched instruction per cycle, tagged with its PC and 2-bit fetch exception code (`{addr-error, fetch-fault}`).
- Presents up to two oldest instructions per cycle to the dual decoders; decode reports how many it consumed.
- Decouples fetch from decode stalls and absorbs redirect flushes on interrupt/branch.

Parameters:
- DEPTH, 8, number of instruction entries; power of two, minimum 4.
- PTR_W, 3, pointer width = log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard all entries (exception/interrupt/branch redirect).
- in_valid  in  1  fetch presents an instruction this cycle.
- in_pc  in  32  PC of the incoming instruction.
- in_inst  in  32  incoming instruction word (0 when fetch faulted).
- in_exc  in  2  fetch exception code; 2'b00 = none.
- in_ready  out  1  queue can accept an instruction this cycle.
- out_valid0  out  1  slot 0 (oldest) holds a valid instruction.
- out_pc0  out  32  PC of slot 0.
- out_inst0  out  32  instruction word of slot 0.
- out_exc0  out  2  exception code of slot 0.
- out_valid1  out  1  slot 1 (second oldest) valid and dual-issuable.
- out_pc1  out  32  PC of slot 1.
- out_inst1  out  32  instruction word of slot 1.
- out_exc1  out  2  exception code of slot 1.
- issue_cnt  in  2  entries consumed by decode this cycle (0, 1 or 2; 3 is illegal).
- count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (reset==0 at a rising clk edge):
  - rd_ptr, wr_ptr and count are cleared to 0.
  - All out_valid* = 0, out_pc*/out_inst* = 0, out_exc* = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Reset asserted mid-operation: identical to flush. All entries are lost and no push or pop commits that cycle.
- Storage: circular buffer of {pc, inst, exc} entries. Pointers are PTR_W bits and wrap naturally from DEPTH-1 to 0. count is PTR_W+1 bits.
- Ready:
  - in_ready = (count < DEPTH), from registered state only.
  - A same-cycle pop does not free space for a same-cycle push.
- Push: when in_valid && in_ready && !flush, the entry is written at wr_ptr and wr_ptr increments.
- Pop:
  - eff = min(issue_cnt, issuable), where issuable = out_valid0 + out_valid1.
  - rd_ptr advances by eff, modulo DEPTH.
  - issue_cnt larger than issuable is clamped, never underflows.
- Count: count_next = count + push - eff, all in one cycle.
- Outputs:
  - Outputs are combinational reads at rd_ptr and rd_ptr+1 (wrapped).
  - Latency without bypass: 1 cycle from push to visibility on slot 0.
  - out_valid0 = (count >= 1).
  - out_valid1 = (count >= 2) && (out_exc0 == 0) && (out_exc1 == 0). A faulting instruction always issues alone, in slot 0.
  - Data of an invalid slot is don't-care, but must not be X after reset.
- Flush:
  - Highest priority: count, rd_ptr and wr_ptr go to 0 next cycle.
  - A push and issue_cnt in the flush cycle are ignored.
  - Outputs are invalid the following cycle.
- Full boundary: with count==DEPTH, in_ready=0. A simultaneous issue_cnt=2 gives count DEPTH-2 next cycle, and in_ready=1 then.
- Empty boundary: with count==0, issue_cnt is ignored and no pointer moves.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined: when count==0, in_valid=1 and flush=0:
  - Slot 0 shows in_pc/in_inst/in_exc combinationally, with out_valid0=1.
  - If issue_cnt>=1, the instruction is consumed without being written, so count stays 0.
  - Otherwise it is written normally.
  - out_valid1 stays 0 in bypass.
  - Gives 0-cycle fetch-to-decode latency.
- Undefined: no bypass; the minimum latency is 1 cycle.

Decomposition:
- Shared package cpu_pkg (extend the existing one if present):
  - iq_entry_t struct {pc[31:0], inst[31:0], exc[1:0]}.
  - Constants EXC_NONE=2'b00, EXC_ADEL=2'b10, EXC_FETCH=2'b01.
  - DEPTH default.
- One natural sub-module: inst_queue_ram.
  - DEPTH x iq_entry_t register array.
  - One synchronous write port, two asynchronous read ports.
  - Controller (pointers, count, valid logic, bypass) lives in inst_queue.

Test Plan:
- Reset, then push PCs 0xbfc00000, 0xbfc00004, 0xbfc00008 with issue_cnt=0 -> count=3; slot0 pc=0xbfc00000, slot1 pc=0xbfc00004; both valid.
- From that state, issue_cnt=2 while pushing 0xbfc0000c -> next cycle count=2, slot0 pc=0xbfc00008, slot1 pc=0xbfc0000c.
- Fill to 8 entries with issue_cnt=0 -> in_ready=0; a further in_valid is not stored. Then issue_cnt=2 -> count=6, in_ready=1. Continue 20 push/pop cycles across wrap -> PCs emerge strictly in order.
- Push an entry with in_exc=2'b10 as the second oldest -> out_valid1=0 until it reaches slot 0; then it issues alone with out_exc0=2'b10 and out_inst0=0.
- count=5, flush=1 with in_valid=1 and issue_cnt=2 -> next cycle count=0, out_valid0=0. A push in the following cycle appears as the only entry.
- Empty queue, issue_cnt=2 -> count stays 0, pointers unchanged.
- With INST_QUEUE_BYPASS_EN, empty queue, in_valid with pc 0xbfc00010 and issue_cnt=1 -> out_valid0=1, out_pc0=0xbfc00010 the same cycle; count stays 0.
